// File: rtl/inst_mem.sv
// ---------------------------------------------------------------------------
// inst_mem -- loadable instruction memory with a one-cycle registered fetch.
//
// A program is written word by word through the load port. Fetches are served
// only once a load has completed (READY). Any address at or beyond the number
// of loaded words returns NOP_WORD, so the core always sees a defined stream.
//
// Load handshake: a word is transferred on a rising edge where
// load_valid && load_ready. load_ready depends only on state, never on
// load_valid. load_start takes priority over everything in the same cycle: it
// drops any word and any fetch presented alongside it.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   load_start    : pulse, (re)starts a program load from word 0
//   load_valid    : load_data is valid
//   load_last     : marks the final program word (sampled with load_valid)
//   load_data     : instruction word to store
//   load_ready    : high while loading
//   load_done     : one-cycle pulse in the first READY cycle
//   loaded_count  : number of valid words stored
//   fetch_req     : fetch request for fetch_addr
//   fetch_addr    : word index to fetch (full-width compare, no wrap)
//   fetch_valid   : inst is valid (one cycle after an accepted fetch)
//   inst          : fetched instruction, holds when no fetch is accepted
//   dbg_state     : current FSM state (EMPTY=0, LOADING=1, READY=2)
// ---------------------------------------------------------------------------
module inst_mem #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [INST_W-1:0] NOP_WORD = '0,
    parameter int                CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [INST_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic [CNT_W-1:0]  loaded_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [INST_W-1:0] inst,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_READY   = 2'd2
    } state_e;

    state_e            state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              load_done_q;
    logic              fetch_valid_q;
    logic [INST_W-1:0] inst_q;
    logic [INST_W-1:0] inst_d;

    logic [INST_W-1:0] mem [DEPTH];

    logic wr_en;
    logic last_word;
    logic fetch_acc;
    logic addr_hit;

    // load_start drops the word presented in the same cycle.
    assign wr_en     = (state_q == S_LOADING) && load_valid && !load_start;
    // The load ends on load_last or when the final array slot is written.
    assign last_word = load_last || (ptr_q == PTR_W'(DEPTH - 1));
    assign fetch_acc = (state_q == S_READY) && fetch_req && !load_start;
    // Full-width compare: high address bits must not alias onto low words.
    assign addr_hit  = fetch_addr < ADDR_W'(count_q);

    always_comb begin
        inst_d = NOP_WORD;
        if (addr_hit) begin
            inst_d = mem[fetch_addr[PTR_W-1:0]];
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_EMPTY;
            ptr_q         <= '0;
            count_q       <= '0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            inst_q        <= NOP_WORD;
        end else begin
            load_done_q   <= 1'b0;
            fetch_valid_q <= fetch_acc;
            if (fetch_acc) begin
                inst_q <= inst_d;
            end
            if (load_start) begin
                state_q <= S_LOADING;
                ptr_q   <= '0;
                count_q <= '0;
            end else if (wr_en) begin
                ptr_q   <= ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(1);
                if (last_word) begin
                    state_q     <= S_READY;
                    load_done_q <= 1'b1;
                end
            end
        end
    end

    // Storage has no reset; stale contents stay hidden behind count_q.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[ptr_q] <= load_data;
        end
    end

    assign load_ready   = (state_q == S_LOADING);
    assign load_done    = load_done_q;
    assign loaded_count = count_q;
    assign fetch_valid  = fetch_valid_q;
    assign inst         = inst_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_inst_mem.sv
// Bench for inst_mem: a DEPTH=256 instance for the main scenarios and a
// DEPTH=4 instance for the overflow/saturation case.
module tb_inst_mem;

    localparam logic [31:0] NOP = 32'h0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // ---------------- main DUT (DEPTH=256) ----------------
    logic        load_start = 0, load_valid = 0, load_last = 0;
    logic [31:0] load_data = '0;
    logic        load_ready, load_done;
    logic [8:0]  loaded_count;
    logic        fetch_req = 0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_valid;
    logic [31:0] inst;
    logic [1:0]  dbg_state;

    inst_mem #(.INST_W(32), .ADDR_W(32), .DEPTH(256), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_last(load_last), .load_data(load_data), .load_ready(load_ready),
        .load_done(load_done), .loaded_count(loaded_count), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .inst(inst),
        .dbg_state(dbg_state)
    );

    // ---------------- small DUT (DEPTH=4) ----------------
    logic        s_load_start = 0, s_load_valid = 0, s_load_last = 0;
    logic [31:0] s_load_data = '0;
    logic        s_load_ready, s_load_done;
    logic [2:0]  s_loaded_count;
    logic        s_fetch_req = 0;
    logic [31:0] s_fetch_addr = '0;
    logic        s_fetch_valid;
    logic [31:0] s_inst;
    logic [1:0]  s_dbg_state;

    inst_mem #(.INST_W(32), .ADDR_W(32), .DEPTH(4), .NOP_WORD(NOP)) dut4 (
        .clk(clk), .rst(rst), .load_start(s_load_start), .load_valid(s_load_valid),
        .load_last(s_load_last), .load_data(s_load_data), .load_ready(s_load_ready),
        .load_done(s_load_done), .loaded_count(s_loaded_count), .fetch_req(s_fetch_req),
        .fetch_addr(s_fetch_addr), .fetch_valid(s_fetch_valid), .inst(s_inst),
        .dbg_state(s_dbg_state)
    );

    // ---------------- model / scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_q[$];   // program as the main DUT should hold it
    logic [31:0] stim_q[$];    // words to drive in the next load
    logic [31:0] exp_q[$];     // expected fetch results in issue order
    logic [31:0] last_inst = NOP;

    function automatic logic [31:0] exp_of(input logic [31:0] addr);
        logic [31:0] sz;
        sz = model_q.size();
        if (addr < sz) return model_q[addr];
        return NOP;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input bit with_start, input bit use_last);
        if (with_start) begin
            load_start = 1'b1;
            cycle();
            load_start = 1'b0;
            model_q.delete();
        end
        foreach (stim_q[i]) begin
            load_valid = 1'b1;
            load_data  = stim_q[i];
            load_last  = use_last && (i == stim_q.size() - 1);
            cycle();
            if (model_q.size() < 256) model_q.push_back(stim_q[i]);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got %b exp 0", load_ready); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b exp 0", load_done); end
        checks++; if (s_loaded_count !== 3'd0) begin errors++; $display("FAIL reset_small_count got %0d exp 0", s_loaded_count); end
        for (int c = 0; c < 3; c++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'd0;
            cycle();
            checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL empty_fetch_valid cyc %0d got %b exp 0", c, fetch_valid); end
            checks++; if (inst !== NOP) begin errors++; $display("FAIL empty_inst cyc %0d got %h exp %h", c, inst, NOP); end
            checks++; if (loaded_count !== 9'd0) begin errors++; $display("FAIL empty_count cyc %0d got %0d exp 0", c, loaded_count); end
        end
        fetch_req = 1'b0;
        last_inst = NOP;
    endtask

    task automatic test_program_load();
        stim_q.delete();
        stim_q.push_back(32'h0C40_0001);
        for (int i = 1; i < 10; i++) stim_q.push_back($urandom);
        stim_q.push_back(32'h0841_0000);
        drive_load(1'b1, 1'b1);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL prog_done_pulse got %b exp 1", load_done); end
        checks++; if (loaded_count !== 9'd11) begin errors++; $display("FAIL prog_count got %0d exp 11", loaded_count); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL prog_ready_after got %b exp 0", load_ready); end
        // Back-to-back fetches 0..11; 11 is past the program.
        for (int a = 0; a < 12; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'(a);
            exp_q.push_back(exp_of(32'(a)));
            cycle();
            if (a == 0) begin
                checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL prog_done_once got %b exp 0", load_done); end
            end
            last_inst = exp_q.pop_front();
            checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL prog_fetch_valid addr %0d got %b exp 1", a, fetch_valid); end
            checks++; if (inst !== last_inst) begin errors++; $display("FAIL prog_fetch addr %0d got %h exp %h", a, inst, last_inst); end
        end
        fetch_req = 1'b0;
        cycle();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL prog_idle_valid got %b exp 0", fetch_valid); end
        checks++; if (inst !== last_inst) begin errors++; $display("FAIL prog_idle_hold got %h exp %h", inst, last_inst); end
    endtask

    task automatic test_depth_limit();
        logic [31:0] words[6];
        logic [31:0] addrs[7];
        logic [31:0] e;
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        s_load_start = 1'b1;
        cycle();
        s_load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (s_load_ready !== (i < 4)) begin errors++; $display("FAIL depth_ready word %0d got %b exp %b", i, s_load_ready, (i < 4)); end
            s_load_valid = 1'b1;
            s_load_data  = words[i];
            cycle();
            if (i == 3) begin
                checks++; if (s_load_done !== 1'b1) begin errors++; $display("FAIL depth_done got %b exp 1", s_load_done); end
            end
            if (i == 4) begin
                checks++; if (s_load_done !== 1'b0) begin errors++; $display("FAIL depth_done_once got %b exp 0", s_load_done); end
            end
        end
        s_load_valid = 1'b0;
        checks++; if (s_loaded_count !== 3'd4) begin errors++; $display("FAIL depth_count got %0d exp 4", s_loaded_count); end
        addrs = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000_0104, 32'hFFFF_FFFF};
        for (int k = 0; k < 7; k++) begin
            s_fetch_req  = 1'b1;
            s_fetch_addr = addrs[k];
            cycle();
            e = (k < 4) ? words[k] : NOP;
            checks++; if (s_fetch_valid !== 1'b1) begin errors++; $display("FAIL depth_fetch_valid addr %h got %b exp 1", addrs[k], s_fetch_valid); end
            checks++; if (s_inst !== e) begin errors++; $display("FAIL depth_fetch addr %h got %h exp %h", addrs[k], s_inst, e); end
        end
        s_fetch_req = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = $urandom;
        cycle();
        load_data  = $urandom;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        load_valid = 1'b0;
        model_q.delete();
        last_inst = NOP;
        checks++; if (loaded_count !== 9'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", loaded_count); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b exp 0", load_ready); end
        fetch_req  = 1'b1;
        fetch_addr = 32'd0;
        cycle();
        fetch_req  = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fetch_valid got %b exp 0", fetch_valid); end
        stim_q.delete();
        stim_q.push_back(32'hDEAD_0001);
        drive_load(1'b1, 1'b1);
        checks++; if (loaded_count !== 9'd1) begin errors++; $display("FAIL rstmid_reload_count got %0d exp 1", loaded_count); end
        for (int a = 0; a < 2; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'(a);
            exp_q.push_back(exp_of(32'(a)));
            cycle();
            last_inst = exp_q.pop_front();
            checks++; if (inst !== last_inst) begin errors++; $display("FAIL rstmid_fetch addr %0d got %h exp %h", a, inst, last_inst); end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_start_beats_fetch();
        stim_q.delete();
        for (int i = 0; i < 5; i++) stim_q.push_back($urandom);
        drive_load(1'b1, 1'b1);
        fetch_req  = 1'b1;
        fetch_addr = 32'd4;
        cycle();
        last_inst = exp_of(32'd4);
        checks++; if (inst !== last_inst) begin errors++; $display("FAIL collide_pre_fetch got %h exp %h", inst, last_inst); end
        load_start = 1'b1;
        fetch_addr = 32'd0;
        cycle();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        model_q.delete();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL collide_fetch_valid got %b exp 0", fetch_valid); end
        checks++; if (inst !== last_inst) begin errors++; $display("FAIL collide_inst_hold got %h exp %h", inst, last_inst); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL collide_ready got %b exp 1", load_ready); end
        checks++; if (loaded_count !== 9'd0) begin errors++; $display("FAIL collide_count got %0d exp 0", loaded_count); end
        stim_q.delete();
        for (int i = 0; i < 2; i++) stim_q.push_back($urandom);
        drive_load(1'b0, 1'b1);
        checks++; if (loaded_count !== 9'd2) begin errors++; $display("FAIL collide_reload_count got %0d exp 2", loaded_count); end
        for (int k = 0; k < 2; k++) begin
            fetch_req  = 1'b1;
            fetch_addr = (k == 0) ? 32'd4 : 32'd1;
            exp_q.push_back(exp_of(fetch_addr));
            cycle();
            last_inst = exp_q.pop_front();
            checks++; if (inst !== last_inst) begin errors++; $display("FAIL collide_fetch addr %0d got %h exp %h", fetch_addr, inst, last_inst); end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_restart_mid_load();
        stim_q.delete();
        for (int i = 0; i < 2; i++) stim_q.push_back($urandom);
        drive_load(1'b1, 1'b0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hBAD0_BAD0;
        cycle();
        load_start = 1'b0;
        load_valid = 1'b0;
        model_q.delete();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got %b exp 1", load_ready); end
        checks++; if (loaded_count !== 9'd0) begin errors++; $display("FAIL restart_count got %0d exp 0", loaded_count); end
        stim_q.delete();
        stim_q.push_back($urandom);
        drive_load(1'b0, 1'b1);
        checks++; if (loaded_count !== 9'd1) begin errors++; $display("FAIL restart_final_count got %0d exp 1", loaded_count); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL restart_done got %b exp 1", load_done); end
        for (int a = 0; a < 2; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'(a);
            exp_q.push_back(exp_of(32'(a)));
            cycle();
            last_inst = exp_q.pop_front();
            checks++; if (inst !== last_inst) begin errors++; $display("FAIL restart_fetch addr %0d got %h exp %h", a, inst, last_inst); end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        bit req;
        logic [31:0] a;
        n = $urandom_range(1, 20);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back($urandom);
        drive_load(1'b1, 1'b1);
        checks++; if (loaded_count !== 9'(n)) begin errors++; $display("FAIL b2b_count got %0d exp %0d", loaded_count, n); end
        for (int c = 0; c < 80; c++) begin
            req = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, n + 3));
            fetch_req  = req;
            fetch_addr = a;
            if (req) exp_q.push_back(exp_of(a));
            cycle();
            if (req) begin
                last_inst = exp_q.pop_front();
                checks++; if (fetch_valid !== 1'b1 || inst !== last_inst) begin
                    errors++; $display("FAIL b2b_fetch cyc %0d addr %h got v=%b %h exp v=1 %h", c, a, fetch_valid, inst, last_inst);
                end
            end else begin
                checks++; if (fetch_valid !== 1'b0 || inst !== last_inst) begin
                    errors++; $display("FAIL b2b_idle cyc %0d got v=%b %h exp v=0 %h", c, fetch_valid, inst, last_inst);
                end
            end
        end
        fetch_req = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_scoreboard left %0d exp 0", exp_q.size()); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_program_load();
        test_depth_limit();
        test_reset_mid_load();
        test_start_beats_fetch();
        test_restart_mid_load();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem.md
Name: inst_mem

Overview:
- Parametrised, loadable successor to the fixed instruction ROM.
- Holds up to DEPTH instruction words in an internal array filled at run time through a word-wise load port.
- Serves CPU fetches with a one-cycle registered read.
- Addresses beyond the loaded program return the NOP encoding, so the core sees a defined instruction stream at all times.

Parameters:
- INST_W, 32, instruction word width in bits.
- ADDR_W, 32, fetch address width; the address is a word index (PC increments by 1).
- DEPTH, 256, number of instruction words stored; must be ≥ 2.
- NOP_WORD, 0, value returned for unloaded or out-of-range addresses (opcode 0 with zero fill).
- CNT_W, clog2(DEPTH+1), width of the loaded-word counter.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- load_start, input, 1, one-cycle pulse that begins a new program load.
- load_valid, input, 1, load_data is valid this cycle.
- load_last, input, 1, qualifies the final word of the program; sampled with load_valid.
- load_data, input, INST_W, instruction word to store.
- load_ready, output, 1, high while in LOADING; a word is accepted when load_valid && load_ready.
- load_done, output, 1, one-cycle pulse on entry to READY.
- loaded_count, output, CNT_W, number of valid words currently stored.
- fetch_req, input, 1, fetch request for fetch_addr.
- fetch_addr, input, ADDR_W, word index to fetch.
- fetch_valid, output, 1, inst is valid this cycle (one cycle after an accepted fetch_req).
- inst, output, INST_W, fetched instruction word.

Behaviour:
- Reset (rst=1 at edge):
  - state=EMPTY, write pointer=0, loaded_count=0.
  - load_ready=0, load_done=0, fetch_valid=0, inst=NOP_WORD.
  - Array contents are not cleared. They are unreachable because loaded_count=0 forces NOP.
  - Reset mid-load abandons the load; partial words are never visible.
- States: EMPTY, LOADING, READY.
- EMPTY:
  - load_start → LOADING.
  - fetch_req is ignored; fetch_valid stays 0.
- LOADING:
  - load_ready=1. On each accepted word: mem[ptr]=load_data, ptr++, loaded_count=ptr+1.
  - Transition to READY after the accepted word with load_last=1, or after the word written at ptr=DEPTH-1, whichever comes first. Words beyond DEPTH are never written.
  - load_done pulses in the first READY cycle.
  - load_start while LOADING restarts the load: ptr=0, loaded_count=0, any word presented that cycle is dropped.
  - load_valid=1 with load_ready=0 is ignored.
- READY:
  - load_ready=0.
  - load_start → LOADING with ptr=0 and loaded_count=0 in the next cycle.
- Load entry: on entering LOADING from any state, ptr=0 and loaded_count=0.
- Fetch:
  - A fetch_req is accepted only when state=READY and load_start=0 in the same cycle. load_start wins; the fetch is dropped.
  - Accepted fetch → next cycle fetch_valid=1 and inst=mem[fetch_addr] if fetch_addr < loaded_count, else NOP_WORD.
  - fetch_addr is compared at full ADDR_W; no wrap-around, high bits are not truncated.
  - Non-accepted cycle → fetch_valid=0 and inst holds its last value.
  - Back-to-back fetches are supported at one per cycle with fixed latency 1.
- Read/write collision: cannot occur, since fetches are only accepted in READY and writes only happen in LOADING.
- Width rules:
  - loaded_count saturates at DEPTH.
  - ptr is clog2(DEPTH) bits internally.
  - load_data is stored unmodified.

Test Plan:
- Reset, then fetch_req with addr 0 for 3 cycles → fetch_valid=0 throughout, inst=0, loaded_count=0.
- Load start, 11 words (0x0C400001 … 0x08410000) with load_last on word 11 → load_done pulses once, loaded_count=11. Fetch addr 0..10 → each word returned exactly one cycle later. Fetch addr 11 → NOP_WORD.
- DEPTH=4: load 6 words with no load_last → only words 0..3 stored, READY after the 4th, load_ready=0 during words 5–6, loaded_count=4. Fetch addr 0xFFFFFFFF → NOP_WORD.
- Load 3 words, assert rst during the 2nd load cycle → state EMPTY, loaded_count=0. Fetch after a new 1-word load of 0xDEAD0001: addr 0 → 0xDEAD0001, addr 1 → NOP_WORD.
- In READY with 5 words loaded, assert load_start and fetch_req together → fetch_valid=0 next cycle, load_ready=1, loaded_count=0. Reload 2 words → addr 4 now returns NOP_WORD.
- load_start again mid-LOADING after 2 words, then load 1 word with load_last → loaded_count=1, first pre-restart word overwritten.
